// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: arms on alarm_en, rings on an hh:mm:00 match, supports
// a bounded number of snoozes, auto-times out, and blinks the ring overlay.
module alarm_ring_ctrl #(
  parameter int SNOOZE_SECS  = 300,
  parameter int RING_SECS    = 60,
  parameter int MAX_SNOOZE   = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       frame_tick,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] al_hour,
  input  logic [7:0] al_min,
  input  logic       alarm_en,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       alarma_on,
  output logic       blink_phase,
  output logic       buzzer,
  output logic       snooze_active,
  output logic [2:0] state
);

  localparam int SEC_MAX = (SNOOZE_SECS > RING_SECS) ? SNOOZE_SECS : RING_SECS;
  localparam int SEC_W   = ($clog2(SEC_MAX + 1) > 9) ? $clog2(SEC_MAX + 1) : 9;
  localparam int SNZ_W   = ($clog2(MAX_SNOOZE + 1) > 1) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int BLK_W   = ($clog2(BLINK_FRAMES) > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SEC_W-1:0] RING_LIM   = SEC_W'(RING_SECS);
  localparam logic [SEC_W-1:0] SNOOZE_LIM = SEC_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0] SNZ_LIM    = SNZ_W'(MAX_SNOOZE);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ARMED   = 3'd1,
    S_RINGING = 3'd2,
    S_SNOOZED = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_nxt;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_nxt, sec_inc;
  logic [SNZ_W-1:0] snooze_cnt_q, snooze_cnt_nxt;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_nxt;
  logic             blink_phase_nxt;
  logic             match;
  logic             ring_timeout;
  logic             snooze_timeout;
  logic             snooze_ok;

  // Raw byte compare; seconds must be exactly zero so the match is one second wide.
  assign match = (hour == al_hour) && (min == al_min) && (sec == 8'h00);

  // Saturating increment so a stuck counter can never wrap back into range.
  assign sec_inc        = (sec_cnt_q == '1) ? sec_cnt_q : sec_cnt_q + SEC_W'(1);
  assign ring_timeout   = sec_tick && (sec_inc >= RING_LIM);
  assign snooze_timeout = sec_tick && (sec_inc >= SNOOZE_LIM);
  assign snooze_ok      = snooze_btn && (snooze_cnt_q < SNZ_LIM);

  always_comb begin
    state_nxt       = S_OFF;
    sec_cnt_nxt     = '0;
    snooze_cnt_nxt  = snooze_cnt_q;
    blink_cnt_nxt   = '0;
    blink_phase_nxt = 1'b0;

    if (!alarm_en) begin
      state_nxt = S_OFF;
    end else begin
      case (state_q)
        S_OFF: state_nxt = S_ARMED;

        S_ARMED: begin
          if (match) begin
            state_nxt       = S_RINGING;
            blink_phase_nxt = 1'b1;
          end else begin
            state_nxt = S_ARMED;
          end
        end

        S_RINGING: begin
          // Priority: stop, then snooze, then timeout.
          if (stop_btn) begin
            state_nxt = S_DONE;
          end else if (snooze_ok) begin
            state_nxt      = S_SNOOZED;
            snooze_cnt_nxt = snooze_cnt_q + SNZ_W'(1);
          end else if (ring_timeout) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt       = S_RINGING;
            sec_cnt_nxt     = sec_tick ? sec_inc : sec_cnt_q;
            blink_cnt_nxt   = blink_cnt_q;
            blink_phase_nxt = blink_phase;
            if (frame_tick) begin
              if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
              end else begin
                blink_cnt_nxt = blink_cnt_q + BLK_W'(1);
              end
            end
          end
        end

        S_SNOOZED: begin
          if (stop_btn) begin
            state_nxt = S_DONE;
          end else if (snooze_timeout) begin
            state_nxt       = S_RINGING;
            blink_phase_nxt = 1'b1;
          end else begin
            state_nxt   = S_SNOOZED;
            sec_cnt_nxt = sec_tick ? sec_inc : sec_cnt_q;
          end
        end

        // Wait for the match second to pass so the same minute cannot retrigger.
        S_DONE: state_nxt = match ? S_DONE : S_ARMED;

        default: state_nxt = S_OFF;
      endcase
    end

    if (state_nxt == S_ARMED) begin
      snooze_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_OFF;
      sec_cnt_q     <= '0;
      snooze_cnt_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase   <= 1'b0;
      alarma_on     <= 1'b0;
      buzzer        <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      sec_cnt_q     <= sec_cnt_nxt;
      snooze_cnt_q  <= snooze_cnt_nxt;
      blink_cnt_q   <= blink_cnt_nxt;
      blink_phase   <= blink_phase_nxt;
      alarma_on     <= (state_nxt == S_RINGING);
      buzzer        <= (state_nxt == S_RINGING) && blink_phase_nxt;
      snooze_active <= (state_nxt == S_SNOOZED);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl: a vector table for single-step behaviour
// plus hand sequences for blink, snooze limits, timeout and reset corners.
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] hour = 8'h00;
  logic [7:0] min = 8'h00;
  logic [7:0] sec = 8'h00;
  logic [7:0] al_hour = 8'h07;
  logic [7:0] al_min = 8'h30;
  logic       alarm_en = 1'b0;
  logic       stop_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       alarma_on;
  logic       blink_phase;
  logic       buzzer;
  logic       snooze_active;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  alarm_ring_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sec_tick     (sec_tick),
    .frame_tick   (frame_tick),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .al_hour      (al_hour),
    .al_min       (al_min),
    .alarm_en     (alarm_en),
    .stop_btn     (stop_btn),
    .snooze_btn   (snooze_btn),
    .alarma_on    (alarma_on),
    .blink_phase  (blink_phase),
    .buzzer       (buzzer),
    .snooze_active(snooze_active),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       en;
    logic       stop;
    logic       snz;
    logic       sect;
    logic       frm;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[19];

  // Packed expectation: {state, alarma_on, blink_phase, buzzer, snooze_active}
  function automatic logic [6:0] pk(logic [2:0] st, logic a, logic b, logic bz, logic sn);
    return {st, a, b, bz, sn};
  endfunction

  function automatic vec_t mkv(logic [7:0] h, logic [7:0] m, logic [7:0] s, logic en,
                               logic stop, logic snz, logic sect, logic frm, logic [6:0] exp);
    vec_t v;
    v.hour = h; v.min = m; v.sec = s; v.en = en; v.stop = stop;
    v.snz = snz; v.sect = sect; v.frm = frm; v.exp = exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {state, alarma_on, blink_phase, buzzer, snooze_active};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got st=%0d on=%b bl=%b bz=%b sn=%b, want st=%0d on=%b bl=%b bz=%b sn=%b",
               name, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_snz(input string name, input int exp);
    tests++;
    if (int'(dut.snooze_cnt_q) != exp) begin
      fails++;
      $display("FAIL %s: snooze_cnt got %0d want %0d", name, dut.snooze_cnt_q, exp);
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour = h; min = m; sec = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      tick();
      sec_tick = 1'b0;
    end
  endtask

  task automatic pulse_frame(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
    end
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    tick();
    snooze_btn = 1'b0;
  endtask

  task automatic go_ring();
    do_reset();
    al_hour = 8'h07; al_min = 8'h30;
    alarm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    tick();
    set_time(8'h07, 8'h30, 8'h00);
    tick();
    check("ring_entry", pk(3'd2, 1'b1, 1'b1, 1'b1, 1'b0));
  endtask

  initial begin
    tbl[0]  = mkv(8'h07, 8'h29, 8'h59, 0, 0, 0, 0, 0, pk(3'd0, 0, 0, 0, 0));
    tbl[1]  = mkv(8'h07, 8'h29, 8'h59, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[2]  = mkv(8'h07, 8'h29, 8'h59, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[3]  = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd2, 1, 1, 1, 0));
    tbl[4]  = mkv(8'h07, 8'h30, 8'h00, 1, 1, 1, 0, 0, pk(3'd4, 0, 0, 0, 0));
    tbl[5]  = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd4, 0, 0, 0, 0));
    tbl[6]  = mkv(8'h07, 8'h30, 8'h01, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[7]  = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd2, 1, 1, 1, 0));
    tbl[8]  = mkv(8'h07, 8'h30, 8'h00, 1, 0, 1, 0, 0, pk(3'd3, 0, 0, 0, 1));
    tbl[9]  = mkv(8'h07, 8'h30, 8'h00, 0, 0, 0, 0, 0, pk(3'd0, 0, 0, 0, 0));
    tbl[10] = mkv(8'h07, 8'h31, 8'h00, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[11] = mkv(8'h07, 8'h31, 8'h00, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[12] = mkv(8'h08, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[13] = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd2, 1, 1, 1, 0));
    tbl[14] = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 1, pk(3'd2, 1, 1, 1, 0));
    tbl[15] = mkv(8'h07, 8'h30, 8'h00, 1, 1, 0, 0, 0, pk(3'd4, 0, 0, 0, 0));
    tbl[16] = mkv(8'h07, 8'h30, 8'h00, 0, 0, 0, 0, 0, pk(3'd0, 0, 0, 0, 0));
    tbl[17] = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd1, 0, 0, 0, 0));
    tbl[18] = mkv(8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 0, pk(3'd2, 1, 1, 1, 0));

    #2 reset = 1'b0;
    #2 check("reset_state", pk(3'd0, 0, 0, 0, 0));
    reset = 1'b1;

    // Table-driven single-step vectors
    for (int i = 0; i < 19; i++) begin
      set_time(tbl[i].hour, tbl[i].min, tbl[i].sec);
      alarm_en   = tbl[i].en;
      stop_btn   = tbl[i].stop;
      snooze_btn = tbl[i].snz;
      sec_tick   = tbl[i].sect;
      frame_tick = tbl[i].frm;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    stop_btn = 0; snooze_btn = 0; sec_tick = 0; frame_tick = 0;

    // Blink half-period and buzzer gating
    go_ring();
    pulse_frame(31);
    check("blink_31", pk(3'd2, 1, 1, 1, 0));
    pulse_frame(1);
    check("blink_32", pk(3'd2, 1, 0, 0, 0));
    pulse_frame(31);
    check("blink_63", pk(3'd2, 1, 0, 0, 0));
    pulse_frame(1);
    check("blink_64", pk(3'd2, 1, 1, 1, 0));

    // Snooze cycles up to the limit, alarm-time edits ignored mid-event
    go_ring();
    press_snooze();
    check("snooze1", pk(3'd3, 0, 0, 0, 1));
    al_hour = 8'h09;
    pulse_sec(299);
    check("snooze1_299", pk(3'd3, 0, 0, 0, 1));
    pulse_sec(1);
    check("snooze1_300", pk(3'd2, 1, 1, 1, 0));
    al_hour = 8'h07;
    press_snooze();
    pulse_sec(300);
    check("snooze2_back", pk(3'd2, 1, 1, 1, 0));
    press_snooze();
    check("snooze3", pk(3'd3, 0, 0, 0, 1));
    pulse_sec(300);
    check("snooze3_back", pk(3'd2, 1, 1, 1, 0));
    check_snz("snz_cnt_3", 3);
    press_snooze();
    check("snooze4_ignored", pk(3'd2, 1, 1, 1, 0));
    stop_btn = 1; snooze_btn = 1;
    tick();
    stop_btn = 0; snooze_btn = 0;
    check("stop_wins", pk(3'd4, 0, 0, 0, 0));
    check_snz("snz_cnt_kept", 3);
    tick();
    check("done_hold_match", pk(3'd4, 0, 0, 0, 0));
    set_time(8'h07, 8'h30, 8'h01);
    tick();
    check("done_to_armed", pk(3'd1, 0, 0, 0, 0));
    check_snz("snz_cnt_clr", 0);

    // Ring timeout, and snooze beating timeout in the same cycle
    go_ring();
    pulse_sec(59);
    check("ring_59", pk(3'd2, 1, 1, 1, 0));
    pulse_sec(1);
    check("ring_timeout", pk(3'd4, 0, 0, 0, 0));
    go_ring();
    pulse_sec(59);
    sec_tick = 1; snooze_btn = 1;
    tick();
    sec_tick = 0; snooze_btn = 0;
    check("snooze_beats_timeout", pk(3'd3, 0, 0, 0, 1));

    // Snoozed stop
    stop_btn = 1;
    tick();
    stop_btn = 0;
    check("snoozed_stop", pk(3'd4, 0, 0, 0, 0));

    // Asynchronous reset mid-cycle, then resume from OFF
    go_ring();
    #3 reset = 1'b0;
    #1 check("async_reset", pk(3'd0, 0, 0, 0, 0));
    #1 reset = 1'b1;
    set_time(8'h07, 8'h30, 8'h05);
    tick();
    check("resume_armed", pk(3'd1, 0, 0, 0, 0));
    tick();
    check("no_ring_wo_match", pk(3'd1, 0, 0, 0, 0));

    // alarm_en drop while snoozed
    go_ring();
    press_snooze();
    alarm_en = 1'b0;
    tick();
    check("en_low_snoozed", pk(3'd0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter SNOOZE_SECS, default 300, snooze duration in sec_tick pulses.
REQ-002 Parameter RING_SECS, default 60, ring duration before auto-timeout, in sec_tick pulses.
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event.
REQ-004 Parameter BLINK_FRAMES, default 32, frame_tick pulses per blink half-period.
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 sec_tick  input  1  one-cycle pulse once per second.
REQ-008 frame_tick  input  1  one-cycle pulse at pixel_x==0, pixel_y==0.
REQ-009 hour, min, sec  input  8 each  current time, packed BCD.
REQ-010 al_hour, al_min  input  8 each  alarm time, packed BCD.
REQ-011 alarm_en  input  1  level; alarm enabled.
REQ-012 stop_btn, snooze_btn  input  1 each  one-cycle debounced pulses.
REQ-013 alarma_on  output  1  registered; high while RINGING; drives ring overlay.
REQ-014 blink_phase  output  1  registered; overlay visible phase.
REQ-015 buzzer  output  1  registered; alarma_on AND blink_phase.
REQ-016 snooze_active  output  1  registered; high in SNOOZED.
REQ-017 state  output  3  registered state code for debug.

Function
REQ-018 States SHALL be OFF=0, ARMED=1, RINGING=2, SNOOZED=3, DONE=4; codes 5-7 SHALL return to OFF next cycle.
REQ-019 match SHALL be (hour==al_hour)&&(min==al_min)&&(sec==8'h00), compared as raw 8-bit values.
REQ-020 alarm_en low SHALL force OFF on the next edge from any state, overriding all other events.
REQ-021 OFF -> ARMED when alarm_en high.
REQ-022 ARMED -> RINGING when match high; sec_cnt cleared, blink_cnt cleared, blink_phase set to 1.
REQ-023 RINGING -> DONE on stop_btn; stop_btn SHALL win over simultaneous snooze_btn or timeout.
REQ-024 RINGING -> SNOOZED on snooze_btn when snooze_cnt < MAX_SNOOZE; snooze_cnt increments, sec_cnt cleared.
REQ-025 snooze_btn with snooze_cnt == MAX_SNOOZE SHALL be ignored (stay RINGING).
REQ-026 RINGING -> DONE when sec_cnt reaches RING_SECS (counted on sec_tick); snooze beats timeout if same cycle.
REQ-027 SNOOZED -> RINGING when sec_cnt reaches SNOOZE_SECS; sec_cnt, blink_cnt cleared, blink_phase=1.
REQ-028 SNOOZED -> DONE on stop_btn.
REQ-029 DONE -> ARMED only when match is low; snooze_cnt cleared on entry to ARMED.
REQ-030 sec_cnt SHALL be 9 bits minimum, saturating; increments only on sec_tick in RINGING/SNOOZED.
REQ-031 In RINGING, blink_cnt SHALL count frame_tick; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
REQ-032 Outside RINGING, blink_phase SHALL be 0 and blink_cnt held at 0.
REQ-033 All outputs SHALL reflect the new state one clock after the causing edge (latency 1 from input event to output).
REQ-034 al_hour/al_min changes during RINGING/SNOOZED SHALL NOT affect the current event.

Reset
REQ-035 reset low SHALL asynchronously set state=OFF, all counters 0, all outputs 0.
REQ-036 Reset release mid-operation SHALL resume from OFF; no ring until a fresh match with alarm_en high.

Verification
REQ-037 alarm_en=1, al=07:30, time steps 07:29:59 -> 07:30:00 -> alarma_on=1, blink_phase=1, state=2 one cycle after match.
REQ-038 RINGING, 32 frame_ticks -> blink_phase=0; 32 more -> 1; buzzer follows blink_phase.
REQ-039 RINGING, snooze_btn -> state=3, alarma_on=0; 300 sec_ticks -> state=2; 4th snooze_btn ignored, state stays 2.
REQ-040 RINGING, stop_btn and snooze_btn same cycle -> state=4, snooze_cnt unchanged; time still 07:30:00 -> stays 4; 07:30:01 -> state=1.
REQ-041 RINGING, 60 sec_ticks without buttons -> state=4, alarma_on=0.
REQ-042 RINGING, reset pulsed low mid-cycle -> outputs 0 immediately, state=0; alarm_en=0 in SNOOZED -> state=0 next edge.
